obi_rr_arbiter: RTL and testbench
=================================

# obi_rr_arbiter

Round-robin arbiter that shares one OBI subordinate (the byte-enabled SRAM slave) between NUM_MGR OBI managers. It sits between the managers and the subordinate. It selects one requester, forwards its A-channel, locks that selection until the grant, and routes the R-channel response back to the owner. Only one transaction is outstanding at a time, which matches the subordinate's single-outstanding handshake.

## Interface
- NUM_MGR, 2, number of managers (2..8)
- ADDR_WIDTH, 32, address width
- DATA_WIDTH, 32, data width; BE width is DATA_WIDTH/8
- Reset: reset reset_ni, asynchronous, active-low; clock clk_i.
- clk_i  input  1  clock
- reset_ni  input  1  asynchronous active-low reset
- mgr_req_i  input  NUM_MGR  per-manager request
- mgr_gnt_o  output  NUM_MGR  per-manager grant
- mgr_addr_i  input  NUM_MGR*ADDR_WIDTH  packed addresses, manager i at slice [i*ADDR_WIDTH +: ADDR_WIDTH]
- mgr_we_i  input  NUM_MGR  write enables
- mgr_be_i  input  NUM_MGR*DATA_WIDTH/8  packed byte enables
- mgr_wdata_i  input  NUM_MGR*DATA_WIDTH  packed write data
- mgr_rvalid_o  output  NUM_MGR  response valid, one-hot or zero
- mgr_rready_i  input  NUM_MGR  response ready
- mgr_rdata_o  output  NUM_MGR*DATA_WIDTH  packed read data; non-owner slices are 0
- mgr_err_o  output  NUM_MGR  error; non-owner bits are 0
- sub_req_o / sub_gnt_i / sub_addr_o / sub_we_o / sub_be_o / sub_wdata_o  A-channel to the subordinate; widths are 1, 1, ADDR_WIDTH, 1, DATA_WIDTH/8, DATA_WIDTH
- sub_rvalid_i / sub_rready_o / sub_rdata_i / sub_err_i  R-channel from the subordinate; widths are 1, 1, DATA_WIDTH, 1

## Operation
- Internal registers:
  - state_q in {IDLE, ADDR, RESP}
  - owner_q, IDX_W = max(1, $clog2(NUM_MGR)) bits
  - prio_q, IDX_W bits
- Arbitration (combinational):
  - Search mgr_req_i starting at index prio_q, moving upward modulo NUM_MGR.
  - The first set bit is the winner.
  - prio_q is the highest-priority index.
- IDLE:
  - sub_req_o = |mgr_req_i.
  - The A-channel mux selects the winner.
  - mgr_gnt_o[winner] = sub_gnt_i; all other grant bits are 0.
  - If sub_req_o & sub_gnt_i: owner_q <= winner, prio_q <= (winner+1) mod NUM_MGR, go to RESP.
  - Else if sub_req_o: owner_q <= winner, go to ADDR. This locks the selection so the A-channel stays stable.
  - Else stay in IDLE.
- ADDR:
  - The mux selects owner_q. sub_req_o = mgr_req_i[owner_q].
  - mgr_gnt_o[owner_q] = sub_gnt_i.
  - Requests from other managers are ignored.
  - On sub_req_o & sub_gnt_i: prio_q <= (owner_q+1) mod NUM_MGR, go to RESP.
  - A manager that drops req before its grant is a protocol violation. No recovery is required, and the block stays in ADDR.
- RESP:
  - sub_req_o = 0; all mgr_gnt_o bits are 0.
  - mgr_rvalid_o[owner_q] = sub_rvalid_i.
  - mgr_rdata_o slice owner_q = sub_rdata_i; mgr_err_o[owner_q] = sub_err_i.
  - sub_rready_o = mgr_rready_i[owner_q].
  - On sub_rvalid_i & sub_rready_o, go to IDLE.
- sub_rready_o = 0 outside RESP. All mgr_rvalid_o bits are 0 outside RESP.
- A-channel outputs (addr, we, be, wdata) are driven 0 whenever sub_req_o = 0.
- Fairness: a manager that holds req waits at most NUM_MGR-1 other transactions.

## Timing
- Reset values:
  - state_q = IDLE, owner_q = 0, prio_q = 0.
  - All outputs are 0, except outputs that follow the combinational IDLE path.
- These paths are combinational with zero-cycle latency:
  - mgr_req_i → sub_req_o
  - sub_gnt_i → mgr_gnt_o
  - sub_rvalid_i, rdata, err → manager outputs
  - mgr_rready_i → sub_rready_o
- Transaction cost:
  - The acceptance cycle moves the block to RESP.
  - The response handshake cycle moves it to IDLE.
  - Minimum spacing between grants is 2 cycles after the response handshake completes in the same cycle as rvalid.
- Simultaneous requests: the winner is chosen by prio_q only. prio_q changes only at acceptance.
- Wrap-around: when winner = NUM_MGR-1, prio_q becomes 0.
- Reset mid-transaction: the block returns to IDLE immediately and asynchronously. Any in-flight response is dropped, and owner_q and prio_q are cleared.
- A new request raised while in RESP is not granted until the block returns to IDLE.

## Test plan
- Single manager, NUM_MGR = 2:
  - Manager 0 writes 0xDEADBEEF to address 0x10 with be = 0xF, then reads 0x10.
  - Required: mgr_rdata_o[31:0] = 0xDEADBEEF, mgr_err_o = 0, and manager 1 never sees rvalid.
- Simultaneous requests:
  - Both managers hold req from reset.
  - Required grant order: 0, 1, 0, 1. prio_q reads 1, 0, 1, 0 after each acceptance.
- Wrap-around with NUM_MGR = 3:
  - All three managers request continuously.
  - Required grant order: 0, 1, 2, 0, and prio_q returns to 0 after manager 2.
- Subordinate stalls:
  - Hold sub_gnt_i = 0 for 3 cycles while manager 1 requests, then raise manager 0's request.
  - Required: the block stays in ADDR, owner_q = 1, and manager 1 is granted first.
- Response backpressure:
  - mgr_rready_i[owner] = 0 for 4 cycles while sub_rvalid_i = 1.
  - Required: state stays RESP, sub_rready_o = 0, and manager rdata stays stable. The block enters IDLE one cycle after rready rises.
- Reset during RESP:
  - Assert reset_ni low.
  - Required: all mgr_rvalid_o = 0 and sub_req_o = 0 immediately. After release, the first grant goes to manager 0.

Source files
------------

// File: rtl/obi_rr_arbiter.sv
// Round-robin arbiter sharing one single-outstanding OBI subordinate between
// NUM_MGR managers; the selection is locked from first request until the response.
module obi_rr_arbiter #(
  parameter int NUM_MGR    = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                             clk_i,
  input  logic                             reset_ni,
  input  logic [NUM_MGR-1:0]               mgr_req_i,
  output logic [NUM_MGR-1:0]               mgr_gnt_o,
  input  logic [NUM_MGR*ADDR_WIDTH-1:0]    mgr_addr_i,
  input  logic [NUM_MGR-1:0]               mgr_we_i,
  input  logic [NUM_MGR*DATA_WIDTH/8-1:0]  mgr_be_i,
  input  logic [NUM_MGR*DATA_WIDTH-1:0]    mgr_wdata_i,
  output logic [NUM_MGR-1:0]               mgr_rvalid_o,
  input  logic [NUM_MGR-1:0]               mgr_rready_i,
  output logic [NUM_MGR*DATA_WIDTH-1:0]    mgr_rdata_o,
  output logic [NUM_MGR-1:0]               mgr_err_o,
  output logic                             sub_req_o,
  input  logic                             sub_gnt_i,
  output logic [ADDR_WIDTH-1:0]            sub_addr_o,
  output logic                             sub_we_o,
  output logic [DATA_WIDTH/8-1:0]          sub_be_o,
  output logic [DATA_WIDTH-1:0]            sub_wdata_o,
  input  logic                             sub_rvalid_i,
  output logic                             sub_rready_o,
  input  logic [DATA_WIDTH-1:0]            sub_rdata_i,
  input  logic                             sub_err_i
);

  localparam int BE_WIDTH = DATA_WIDTH / 8;
  localparam int IDX_W    = (NUM_MGR > 1) ? $clog2(NUM_MGR) : 1;

  typedef enum logic [1:0] {IDLE, ADDR, RESP} state_t;

  state_t           state_q;
  logic [IDX_W-1:0] owner_q;
  logic [IDX_W-1:0] prio_q;
  logic [IDX_W-1:0] winner;
  logic [IDX_W-1:0] sel;
  logic             found;
  logic             any_req;
  logic             owner_req;
  logic             owner_rready;

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
    return (idx == IDX_W'(NUM_MGR - 1)) ? '0 : idx + IDX_W'(1);
  endfunction

  // Two passes emulate a circular search that starts at prio_q.
  always_comb begin
    winner = prio_q;
    found  = 1'b0;
    for (int i = 0; i < NUM_MGR; i++) begin
      if (!found && mgr_req_i[i] && (IDX_W'(i) >= prio_q)) begin
        winner = IDX_W'(i);
        found  = 1'b1;
      end
    end
    for (int i = 0; i < NUM_MGR; i++) begin
      if (!found && mgr_req_i[i] && (IDX_W'(i) < prio_q)) begin
        winner = IDX_W'(i);
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    any_req      = |mgr_req_i;
    owner_req    = 1'b0;
    owner_rready = 1'b0;
    for (int i = 0; i < NUM_MGR; i++) begin
      if (owner_q == IDX_W'(i)) begin
        owner_req    = mgr_req_i[i];
        owner_rready = mgr_rready_i[i];
      end
    end
  end

  assign sel = (state_q == IDLE) ? winner : owner_q;

  always_comb begin
    case (state_q)
      IDLE:    sub_req_o = any_req;
      ADDR:    sub_req_o = owner_req;
      default: sub_req_o = 1'b0;
    endcase
  end

  // A-channel fields are forced to zero whenever no request is presented.
  always_comb begin
    sub_addr_o  = '0;
    sub_we_o    = 1'b0;
    sub_be_o    = '0;
    sub_wdata_o = '0;
    mgr_gnt_o   = '0;
    for (int i = 0; i < NUM_MGR; i++) begin
      if (sub_req_o && (sel == IDX_W'(i))) begin
        sub_addr_o  = mgr_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
        sub_we_o    = mgr_we_i[i];
        sub_be_o    = mgr_be_i[i*BE_WIDTH +: BE_WIDTH];
        sub_wdata_o = mgr_wdata_i[i*DATA_WIDTH +: DATA_WIDTH];
      end
      if (((state_q == IDLE && any_req) || state_q == ADDR) && (sel == IDX_W'(i))) begin
        mgr_gnt_o[i] = sub_gnt_i;
      end
    end
  end

  always_comb begin
    mgr_rvalid_o = '0;
    mgr_rdata_o  = '0;
    mgr_err_o    = '0;
    sub_rready_o = (state_q == RESP) && owner_rready;
    for (int i = 0; i < NUM_MGR; i++) begin
      if ((state_q == RESP) && (owner_q == IDX_W'(i))) begin
        mgr_rvalid_o[i]                          = sub_rvalid_i;
        mgr_rdata_o[i*DATA_WIDTH +: DATA_WIDTH]  = sub_rdata_i;
        mgr_err_o[i]                             = sub_err_i;
      end
    end
  end

  // Priority advances only when the subordinate accepts a request.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= IDLE;
      owner_q <= '0;
      prio_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (any_req) begin
            owner_q <= winner;
            if (sub_gnt_i) begin
              prio_q  <= next_idx(winner);
              state_q <= RESP;
            end else begin
              state_q <= ADDR;
            end
          end
        end
        ADDR: begin
          if (owner_req && sub_gnt_i) begin
            prio_q  <= next_idx(owner_q);
            state_q <= RESP;
          end
        end
        RESP: begin
          if (sub_rvalid_i && owner_rready) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_obi_rr_arbiter.sv
// Randomized bench for obi_rr_arbiter with three managers: a round-robin reference
// model feeds scoreboard queues that an independent monitor drains every cycle.
module tb_obi_rr_arbiter;
  localparam int N  = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = DW / 8;

  logic            clk_i = 1'b0;
  logic            reset_ni;
  logic [N-1:0]    mgr_req_i, mgr_gnt_o, mgr_we_i, mgr_rvalid_o, mgr_rready_i, mgr_err_o;
  logic [N*AW-1:0] mgr_addr_i;
  logic [N*BW-1:0] mgr_be_i;
  logic [N*DW-1:0] mgr_wdata_i, mgr_rdata_o;
  logic            sub_req_o, sub_gnt_i, sub_we_o, sub_rvalid_i, sub_rready_o, sub_err_i;
  logic [AW-1:0]   sub_addr_o;
  logic [BW-1:0]   sub_be_o;
  logic [DW-1:0]   sub_wdata_o, sub_rdata_i;

  obi_rr_arbiter #(.NUM_MGR(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk_i(clk_i), .reset_ni(reset_ni),
    .mgr_req_i(mgr_req_i), .mgr_gnt_o(mgr_gnt_o), .mgr_addr_i(mgr_addr_i),
    .mgr_we_i(mgr_we_i), .mgr_be_i(mgr_be_i), .mgr_wdata_i(mgr_wdata_i),
    .mgr_rvalid_o(mgr_rvalid_o), .mgr_rready_i(mgr_rready_i),
    .mgr_rdata_o(mgr_rdata_o), .mgr_err_o(mgr_err_o),
    .sub_req_o(sub_req_o), .sub_gnt_i(sub_gnt_i), .sub_addr_o(sub_addr_o),
    .sub_we_o(sub_we_o), .sub_be_o(sub_be_o), .sub_wdata_o(sub_wdata_o),
    .sub_rvalid_i(sub_rvalid_i), .sub_rready_o(sub_rready_o),
    .sub_rdata_i(sub_rdata_i), .sub_err_i(sub_err_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {int mgr; logic [AW-1:0] addr; logic we; logic [BW-1:0] be; logic [DW-1:0] wdata;} acc_t;
  typedef struct {int mgr; logic [DW-1:0] data; logic err;} rsp_t;
  typedef struct {logic sub_req; logic in_resp; int owner;} cyc_t;

  acc_t acc_q[$];
  rsp_t rsp_q[$];
  cyc_t cyc_q[$];

  int tests = 0;
  int fails = 0;
  int done_cnt = 0;

  // Reference model state: whole-transaction view, no FSM encoding.
  int   prio = 0;
  int   owner = 0;
  bit   locked = 0;
  bit   busy = 0;
  acc_t cur;
  logic [DW-1:0] ref_mem [16];
  logic [DW-1:0] sub_mem [16];
  bit   waiting [N];

  task automatic checkOutput(input string name, input logic [127:0] got, input logic [127:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  function automatic int pick();
    for (int k = 0; k < N; k++) begin
      int j;
      j = (prio + k) % N;
      if (mgr_req_i[j]) return j;
    end
    return 0;
  endfunction

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] wd,
                                          input logic [BW-1:0] be);
    logic [DW-1:0] r;
    r = old;
    for (int b = 0; b < BW; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  task automatic applyStimulus(input int cycles);
    bit            pending = 0;
    int            delay = 0;
    logic [DW-1:0] pend_data = '0;
    logic          pend_err = 1'b0;
    for (int cyc = 0; cyc < cycles; cyc++) begin
      cyc_t          c;
      logic [N-1:0]  g, rv;
      logic          sacc, shs;
      int            idx;
      @(negedge clk_i);
      c.in_resp = busy;
      c.owner   = owner;
      c.sub_req = 1'b0;
      if (busy) begin
        if (sub_rvalid_i && mgr_rready_i[owner]) busy = 0;
      end else begin
        if (!locked && (|mgr_req_i)) begin
          owner     = pick();
          locked    = 1;
          cur.mgr   = owner;
          cur.addr  = mgr_addr_i[owner*AW +: AW];
          cur.we    = mgr_we_i[owner];
          cur.be    = mgr_be_i[owner*BW +: BW];
          cur.wdata = mgr_wdata_i[owner*DW +: DW];
          acc_q.push_back(cur);
        end
        c.sub_req = locked && mgr_req_i[owner];
        if (locked && mgr_req_i[owner] && sub_gnt_i) begin
          rsp_t r;
          prio   = (owner + 1) % N;
          busy   = 1;
          locked = 0;
          idx    = int'(cur.addr[5:2]);
          r.mgr  = owner;
          r.err  = (idx == 15);
          if (cur.we) begin
            ref_mem[idx] = merge(ref_mem[idx], cur.wdata, cur.be);
            r.data = '0;
          end else begin
            r.data = ref_mem[idx];
          end
          rsp_q.push_back(r);
        end
      end
      cyc_q.push_back(c);

      g    = mgr_gnt_o;
      rv   = mgr_rvalid_o & mgr_rready_i;
      sacc = sub_req_o & sub_gnt_i;
      shs  = sub_rvalid_i & sub_rready_o;
      if (sacc) begin
        idx = int'(sub_addr_o[5:2]);
        if (sub_we_o) begin
          sub_mem[idx] = merge(sub_mem[idx], sub_wdata_o, sub_be_o);
          pend_data = '0;
        end else begin
          pend_data = sub_mem[idx];
        end
        pend_err = (idx == 15);
        pending  = 1;
        delay    = $urandom_range(0, 3);
      end

      @(posedge clk_i);
      #1;
      if (shs) begin
        sub_rvalid_i = 1'b0;
        sub_rdata_i  = '0;
        sub_err_i    = 1'b0;
        pending      = 0;
      end
      if (pending && !sub_rvalid_i) begin
        if (delay == 0) begin
          sub_rvalid_i = 1'b1;
          sub_rdata_i  = pend_data;
          sub_err_i    = pend_err;
        end else begin
          delay--;
        end
      end
      sub_gnt_i = ($urandom_range(0, 9) < 6);
      for (int i = 0; i < N; i++) begin
        if (mgr_req_i[i] && g[i]) begin
          mgr_req_i[i] = 1'b0;
          waiting[i]   = 1;
        end
        if (waiting[i] && rv[i]) waiting[i] = 0;
        if (!mgr_req_i[i] && !waiting[i] && (cyc < 300 || $urandom_range(0, 3) == 0)) begin
          mgr_req_i[i]            = 1'b1;
          mgr_addr_i[i*AW +: AW]  = AW'($urandom_range(0, 15) * 4);
          mgr_we_i[i]             = $urandom_range(0, 1) == 1;
          mgr_be_i[i*BW +: BW]    = BW'($urandom_range(1, 15));
          mgr_wdata_i[i*DW +: DW] = $urandom;
        end
        mgr_rready_i[i] = ($urandom_range(0, 9) < 7);
      end
    end
  endtask

  // Monitor: drains the scoreboard queues against what the DUT presents.
  initial begin
    forever begin
      cyc_t          c;
      acc_t          a;
      rsp_t          r;
      logic [N-1:0]  exp_rv, exp_err;
      logic [127:0]  exp_rd;
      logic          exp_rr;
      @(negedge clk_i);
      #2;
      if (cyc_q.size() == 0) continue;
      c = cyc_q.pop_front();
      checkOutput("sub_req", 128'(sub_req_o), 128'(c.sub_req));
      if (sub_req_o && sub_gnt_i) begin
        if (acc_q.size() == 0) begin
          checkOutput("unexpected_accept", 128'(1), 128'(0));
        end else begin
          a = acc_q.pop_front();
          checkOutput("gnt", 128'(mgr_gnt_o), 128'(1) << a.mgr);
          checkOutput("sub_addr", 128'(sub_addr_o), 128'(a.addr));
          checkOutput("sub_we", 128'(sub_we_o), 128'(a.we));
          checkOutput("sub_be", 128'(sub_be_o), 128'(a.be));
          checkOutput("sub_wdata", 128'(sub_wdata_o), 128'(a.wdata));
        end
      end else begin
        checkOutput("gnt_zero", 128'(mgr_gnt_o), 128'(0));
        if (!sub_req_o)
          checkOutput("achan_zero", 128'({sub_addr_o, sub_we_o, sub_be_o, sub_wdata_o}), 128'(0));
      end
      exp_rv  = '0;
      exp_err = '0;
      exp_rd  = '0;
      exp_rr  = 1'b0;
      if (c.in_resp) begin
        exp_rr = mgr_rready_i[c.owner];
        if (sub_rvalid_i && rsp_q.size() > 0) begin
          r = rsp_q[0];
          exp_rv[c.owner]          = 1'b1;
          exp_rd[r.mgr*DW +: DW]   = r.data;
          exp_err[c.owner]         = r.err;
        end
      end
      checkOutput("sub_rready", 128'(sub_rready_o), 128'(exp_rr));
      checkOutput("mgr_rvalid", 128'(mgr_rvalid_o), 128'(exp_rv));
      checkOutput("mgr_rdata", 128'(mgr_rdata_o), exp_rd);
      checkOutput("mgr_err", 128'(mgr_err_o), 128'(exp_err));
      if (c.in_resp && sub_rvalid_i && mgr_rready_i[c.owner] && rsp_q.size() > 0) begin
        void'(rsp_q.pop_front());
        done_cnt++;
      end
    end
  end

  initial begin
    for (int i = 0; i < 16; i++) begin
      ref_mem[i] = '0;
      sub_mem[i] = '0;
    end
    for (int i = 0; i < N; i++) waiting[i] = 0;
    reset_ni     = 1'b0;
    mgr_req_i    = '0;
    mgr_addr_i   = '0;
    mgr_we_i     = '0;
    mgr_be_i     = '0;
    mgr_wdata_i  = '0;
    mgr_rready_i = '0;
    sub_gnt_i    = 1'b0;
    sub_rvalid_i = 1'b0;
    sub_rdata_i  = '0;
    sub_err_i    = 1'b0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    reset_ni = 1'b1;
    @(negedge clk_i);
    checkOutput("reset_outputs",
                128'({mgr_gnt_o, mgr_rvalid_o, mgr_err_o, sub_req_o, sub_rready_o, sub_addr_o}),
                128'(0));
    checkOutput("reset_rdata", 128'(mgr_rdata_o), 128'(0));
    @(posedge clk_i);
    #1;
    applyStimulus(2000);
    @(negedge clk_i);
    checkOutput("progress", 128'(done_cnt >= 50), 128'(1));

    // Directed: reset while manager 1 holds a response under backpressure.
    @(posedge clk_i);
    #1;
    reset_ni     = 1'b0;
    mgr_req_i    = '0;
    mgr_rready_i = '0;
    sub_gnt_i    = 1'b0;
    sub_rvalid_i = 1'b0;
    sub_rdata_i  = '0;
    sub_err_i    = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    reset_ni = 1'b1;
    mgr_addr_i[1*AW +: AW] = 32'h20;
    mgr_we_i[1]            = 1'b0;
    mgr_req_i              = 3'b010;
    sub_gnt_i              = 1'b1;
    @(negedge clk_i);
    checkOutput("dir_gnt_m1", 128'(mgr_gnt_o), 128'(3'b010));
    @(posedge clk_i);
    #1;
    mgr_req_i    = '0;
    sub_gnt_i    = 1'b0;
    sub_rvalid_i = 1'b1;
    sub_rdata_i  = 32'hCAFE0001;
    @(negedge clk_i);
    checkOutput("dir_rvalid_m1", 128'(mgr_rvalid_o), 128'(3'b010));
    checkOutput("dir_rdata_m1", 128'(mgr_rdata_o), 128'({32'h0, 32'hCAFE0001, 32'h0}));
    #2;
    reset_ni = 1'b0;
    #1;
    checkOutput("rst_rvalid", 128'(mgr_rvalid_o), 128'(0));
    checkOutput("rst_sub_req", 128'(sub_req_o), 128'(0));
    @(posedge clk_i);
    #1;
    sub_rvalid_i = 1'b0;
    sub_rdata_i  = '0;
    reset_ni     = 1'b1;
    mgr_addr_i   = {32'h38, 32'h34, 32'h30};
    mgr_req_i    = 3'b111;
    @(negedge clk_i);
    checkOutput("post_rst_req", 128'(sub_req_o), 128'(1));
    #1;
    sub_gnt_i = 1'b1;
    #1;
    checkOutput("post_rst_gnt", 128'(mgr_gnt_o), 128'(3'b001));
    checkOutput("post_rst_addr", 128'(sub_addr_o), 128'(32'h30));
    @(posedge clk_i);
    #1;
    mgr_req_i = '0;
    sub_gnt_i = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
